// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the register-file write-back
//               path: register index type, write-back entry struct and the
//               round-robin preference encoding used by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int NUM_REGS     = 32;
    localparam int NUM_REGS_LOG = $clog2(NUM_REGS);

    typedef logic [NUM_REGS_LOG-1:0] reg_idx_t;

    // One buffered result: destination register and the value to write.
    typedef struct packed {
        reg_idx_t              rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Which source wins the next contended arbitration cycle.
    typedef enum logic {
        RR_PREF_ALU = 1'b0,
        RR_PREF_MEM = 1'b1
    } rr_pref_e;

    function automatic rr_pref_e rr_flip(input rr_pref_e pref);
        return (pref == RR_PREF_ALU) ? RR_PREF_MEM : RR_PREF_ALU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : Small single-source FIFO of write-back entries. Exposes the
//               head entry, full/empty flags, and a per-slot valid/rd view so
//               the parent can detect pending writes to a given register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  wb_entry_t             entry_i,
    input  logic                  pop_i,
    output wb_entry_t             head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic     [DEPTH-1:0]  ent_valid_o,
    output reg_idx_t [DEPTH-1:0]  ent_rd_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] valid_q;

    logic w_push;
    logic w_pop;

    // Flags come from the count alone, so ready never depends on valid.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Guard against pushing a full FIFO or popping an empty one.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i  && !empty_o;

    assign head_o      = mem_q[rd_ptr_q];
    assign ent_valid_o = valid_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd_view
            assign ent_rd_o[gi] = mem_q[gi].rd;
        end
    endgenerate

    // Storage array: payload only, qualified by valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // Pointers, occupancy count and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (w_push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            // A push and pop never hit the same slot: that would need the
            // FIFO to be both empty (pop blocked) or full (push blocked).
            if (w_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Write-side initiator for the integer register file. Buffers
//               ALU and load results in per-source FIFOs, arbitrates
//               round-robin under contention and presents one registered
//               write_reg/write_data pair per cycle. Answers a combinational
//               pending-write query for issue-stage hazard checks.
//               Optional macro REGFILE_WB_BYPASS_EN adds byp_hit/byp_data so
//               issue logic can forward the value being written this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = regfile_pkg::DATA_WIDTH,
    parameter int NUM_REGS     = regfile_pkg::NUM_REGS,
    parameter int NUM_REGS_LOG = $clog2(NUM_REGS),
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [NUM_REGS_LOG-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,

    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [NUM_REGS_LOG-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_data,

    output logic [NUM_REGS_LOG-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]   write_data,

    input  logic [NUM_REGS_LOG-1:0] query_reg,
    output logic                    query_pending,
    output logic                    idle
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic                    byp_hit,
    output logic [DATA_WIDTH-1:0]   byp_data
`endif
);

    // ------------------------------------------------------------------
    // Source FIFOs
    // ------------------------------------------------------------------
    wb_entry_t                  w_alu_entry;
    wb_entry_t                  w_mem_entry;
    wb_entry_t                  w_alu_head;
    wb_entry_t                  w_mem_head;
    logic                       w_alu_push;
    logic                       w_mem_push;
    logic                       w_alu_pop;
    logic                       w_mem_pop;
    logic                       w_alu_full;
    logic                       w_mem_full;
    logic                       w_alu_empty;
    logic                       w_mem_empty;
    logic     [FIFO_DEPTH-1:0]  w_alu_ent_valid;
    logic     [FIFO_DEPTH-1:0]  w_mem_ent_valid;
    reg_idx_t [FIFO_DEPTH-1:0]  w_alu_ent_rd;
    reg_idx_t [FIFO_DEPTH-1:0]  w_mem_ent_rd;

    assign alu_ready = !w_alu_full;
    assign mem_ready = !w_mem_full;

    assign w_alu_entry = '{rd: reg_idx_t'(alu_rd), data: alu_data};
    assign w_mem_entry = '{rd: reg_idx_t'(mem_rd), data: mem_data};

    // x0 results complete the handshake but are never buffered.
    assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign w_mem_push = mem_valid && mem_ready && (mem_rd != '0);

    wb_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_alu_push),
        .entry_i     (w_alu_entry),
        .pop_i       (w_alu_pop),
        .head_o      (w_alu_head),
        .full_o      (w_alu_full),
        .empty_o     (w_alu_empty),
        .ent_valid_o (w_alu_ent_valid),
        .ent_rd_o    (w_alu_ent_rd)
    );

    wb_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_mem_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_mem_push),
        .entry_i     (w_mem_entry),
        .pop_i       (w_mem_pop),
        .head_o      (w_mem_head),
        .full_o      (w_mem_full),
        .empty_o     (w_mem_empty),
        .ent_valid_o (w_mem_ent_valid),
        .ent_rd_o    (w_mem_ent_rd)
    );

    // ------------------------------------------------------------------
    // Round-robin arbitration and output register
    // ------------------------------------------------------------------
    rr_pref_e                pref_q;
    rr_pref_e                pref_d;
    logic [NUM_REGS_LOG-1:0] write_reg_q;
    logic [NUM_REGS_LOG-1:0] write_reg_d;
    logic [DATA_WIDTH-1:0]   write_data_q;
    logic [DATA_WIDTH-1:0]   write_data_d;
    logic                    w_contend;

    assign w_contend = !w_alu_empty && !w_mem_empty;

    // Pick the source to pop this cycle; the preference only moves when both
    // sources compete, so a lone source never disturbs fairness.
    always_comb begin
        w_alu_pop    = 1'b0;
        w_mem_pop    = 1'b0;
        pref_d       = pref_q;
        write_reg_d  = '0;
        write_data_d = '0;
        if (w_contend) begin
            if (pref_q == RR_PREF_ALU) begin
                w_alu_pop = 1'b1;
            end else begin
                w_mem_pop = 1'b1;
            end
            pref_d = rr_flip(pref_q);
        end else if (!w_alu_empty) begin
            w_alu_pop = 1'b1;
        end else if (!w_mem_empty) begin
            w_mem_pop = 1'b1;
        end
        if (w_alu_pop) begin
            write_reg_d  = NUM_REGS_LOG'(w_alu_head.rd);
            write_data_d = w_alu_head.data;
        end else if (w_mem_pop) begin
            write_reg_d  = NUM_REGS_LOG'(w_mem_head.rd);
            write_data_d = w_mem_head.data;
        end
    end

    // Registered write port and arbitration state; idle cycles load zeros so
    // every entry is presented for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pref_q       <= RR_PREF_ALU;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            pref_q       <= pref_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    assign idle = w_alu_empty && w_mem_empty && (write_reg_q == '0);

    // ------------------------------------------------------------------
    // Pending-write query
    // ------------------------------------------------------------------
    reg_idx_t w_query_idx;
    logic     w_query_hit;

    assign w_query_idx = reg_idx_t'(query_reg);

    // Match the query against every buffered entry and the write in flight.
    always_comb begin
        w_query_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_alu_ent_valid[i] && (w_alu_ent_rd[i] == w_query_idx)) begin
                w_query_hit = 1'b1;
            end
            if (w_mem_ent_valid[i] && (w_mem_ent_rd[i] == w_query_idx)) begin
                w_query_hit = 1'b1;
            end
        end
        if (write_reg_q == query_reg) begin
            w_query_hit = 1'b1;
        end
        query_pending = (query_reg != '0) && w_query_hit;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the value being written this cycle when it targets query_reg.
    assign byp_hit  = (query_reg != '0) && (query_reg == write_reg_q);
    assign byp_data = byp_hit ? write_data_q : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter with a
//               per-source expected-write scoreboard and a register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, write_reg, query_reg;
    logic [63:0] alu_data, mem_data, write_data;
    logic        query_pending, idle;
`ifdef REGFILE_WB_BYPASS_EN
    logic        byp_hit;
    logic [63:0] byp_data;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    wb_entry_t exp_alu[$];
    wb_entry_t exp_mem[$];
    int        src_log[$];
    int        mem_wr_cyc[$];
    logic [63:0] rf [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .query_reg     (query_reg),
        .query_pending (query_pending),
        .idle          (idle)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_hit       (byp_hit),
        .byp_data      (byp_data)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model driven by the write port.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (write_reg != 5'd0) begin
            rf[write_reg] <= write_data;
        end
    end

    // Scoreboard: every presented write must be the head of one source queue.
    always @(posedge clk) begin
        wb_entry_t got;
        logic      matched;
        #2;
        if (write_reg != 5'd0) begin
            got.rd   = write_reg;
            got.data = write_data;
            matched  = 1'b0;
            if (exp_alu.size() > 0 && exp_alu[0] == got) begin
                void'(exp_alu.pop_front());
                src_log.push_back(0);
                matched = 1'b1;
            end else if (exp_mem.size() > 0 && exp_mem[0] == got) begin
                void'(exp_mem.pop_front());
                src_log.push_back(1);
                mem_wr_cyc.push_back(cyc);
                matched = 1'b1;
            end
            checks++;
            assert (matched === 1'b1) else begin
                errors++;
                $error("FAIL wb_match: observed rd=%0d data=%h, expected head of ALU or MEM queue", got.rd, got.data);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        exp_alu.delete();
        exp_mem.delete();
        src_log.delete();
        mem_wr_cyc.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int ai, mi, first_block, bad, max_gap;
        reset     = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        query_reg = 5'd5;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_write_reg",  64'(write_reg), 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        chk("rst_alu_ready",  64'(alu_ready), 64'd1);
        chk("rst_mem_ready",  64'(mem_ready), 64'd1);
        chk("rst_pending",    64'(query_pending), 64'd0);
        chk("rst_idle",       64'(idle), 64'd1);

        // Single ALU write: rd=5, data=DEAD
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
        chk("t1_ready", 64'(alu_ready), 64'd1);
        exp_alu.push_back('{rd: 5'd5, data: 64'hDEAD});
        @(negedge clk);
        alu_valid = 1'b0;
        chk("t1_wr_cycle1",  64'(write_reg), 64'd0);
        chk("t1_busy",       64'(idle), 64'd0);
        chk("t1_pending",    64'(query_pending), 64'd1);
        @(negedge clk);
        chk("t1_wr_reg",     64'(write_reg), 64'd5);
        chk("t1_wr_data",    write_data, 64'hDEAD);
        @(negedge clk);
        chk("t1_wr_after",   64'(write_reg), 64'd0);
        chk("t1_idle",       64'(idle), 64'd1);
        chk("t1_rf_x5",      rf[5], 64'hDEAD);

        // Both sources push every cycle: alternating grants, ALU first
        do_reset();
        ai = 0; mi = 0;
        for (int c = 0; c < 100 && (ai < 8 || mi < 8); c++) begin
            alu_valid = (ai < 8); alu_rd = 5'(ai + 1); alu_data = 64'hA000 + 64'(ai);
            mem_valid = (mi < 8); mem_rd = 5'(mi + 9); mem_data = 64'hB000 + 64'(mi);
            if (alu_valid && alu_ready) begin
                exp_alu.push_back('{rd: alu_rd, data: alu_data}); ai++;
            end
            if (mem_valid && mem_ready) begin
                exp_mem.push_back('{rd: mem_rd, data: mem_data}); mi++;
            end
            @(negedge clk);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("flood_alu_sent", 64'(ai), 64'd8);
        chk("flood_mem_sent", 64'(mi), 64'd8);
        chk("flood_alu_left", 64'(exp_alu.size()), 64'd0);
        chk("flood_mem_left", 64'(exp_mem.size()), 64'd0);
        chk("flood_writes",   64'(src_log.size()), 64'd16);
        bad = 0;
        foreach (src_log[i]) if (src_log[i] != (i % 2)) bad++;
        chk("flood_alternate", 64'(bad), 64'd0);

        // Mem held at rd=7 while ALU floods: backpressure and fairness
        do_reset();
        ai = 0; mi = 0; first_block = -1;
        for (int c = 0; c < 60 && mi < 6; c++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + (ai % 6)); alu_data = 64'hA100 + 64'(ai);
            mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'hC000 + 64'(mi);
            if (!mem_ready && first_block < 0) first_block = mi;
            if (alu_ready) begin
                exp_alu.push_back('{rd: alu_rd, data: alu_data}); ai++;
            end
            if (mem_ready) begin
                exp_mem.push_back('{rd: mem_rd, data: mem_data}); mi++;
            end
            @(negedge clk);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("bp_accepts_before_block", 64'(first_block), 64'd2);
        chk("bp_mem_sent",  64'(mi), 64'd6);
        chk("bp_alu_left",  64'(exp_alu.size()), 64'd0);
        chk("bp_mem_left",  64'(exp_mem.size()), 64'd0);
        chk("bp_mem_writes", 64'(mem_wr_cyc.size()), 64'd6);
        max_gap = 0;
        for (int i = 1; i < mem_wr_cyc.size(); i++)
            if (mem_wr_cyc[i] - mem_wr_cyc[i-1] > max_gap) max_gap = mem_wr_cyc[i] - mem_wr_cyc[i-1];
        chk("bp_mem_gap_le2", 64'(max_gap <= 2), 64'd1);

        // rd=0 write is accepted and dropped
        query_reg = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
        chk("x0_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("x0_idle",    64'(idle), 64'd1);
        chk("x0_pending", 64'(query_pending), 64'd0);
        @(negedge clk);
        chk("x0_write",   64'(write_reg), 64'd0);
        chk("x0_pending2", 64'(query_pending), 64'd0);

        // query_pending lifetime for rd=12
        query_reg = 5'd12;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'h1234_5678;
        chk("q_before", 64'(query_pending), 64'd0);
        exp_alu.push_back('{rd: 5'd12, data: 64'h1234_5678});
        @(negedge clk);
        alu_valid = 1'b0;
        chk("q_buffered", 64'(query_pending), 64'd1);
        chk("q_wr_zero",  64'(write_reg), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("q_byp_early", 64'(byp_hit), 64'd0);
`endif
        @(negedge clk);
        chk("q_wr_reg",    64'(write_reg), 64'd12);
        chk("q_inflight",  64'(query_pending), 64'd1);
`ifdef REGFILE_WB_BYPASS_EN
        chk("q_byp_hit",   64'(byp_hit), 64'd1);
        chk("q_byp_data",  byp_data, 64'h1234_5678);
`endif
        @(negedge clk);
        chk("q_done", 64'(query_pending), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("q_byp_off",  64'(byp_hit), 64'd0);
        chk("q_byp_zero", byp_data, 64'd0);
`endif
        // Same query against a load-side entry
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'h55;
        exp_mem.push_back('{rd: 5'd12, data: 64'h55});
        @(negedge clk);
        mem_valid = 1'b0;
        chk("q_mem_buffered", 64'(query_pending), 64'd1);
        repeat (2) @(negedge clk);
        chk("q_mem_done", 64'(query_pending), 64'd0);

        // Fill both FIFOs, then reset: buffered results are discarded
        query_reg = 5'd20;
        ai = 0; mi = 0;
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + ai); alu_data = 64'hE000 + 64'(ai);
            mem_valid = 1'b1; mem_rd = 5'(26 + mi); mem_data = 64'hF000 + 64'(mi);
            if (alu_ready) begin
                exp_alu.push_back('{rd: alu_rd, data: alu_data}); ai++;
            end
            if (mem_ready) begin
                exp_mem.push_back('{rd: mem_rd, data: mem_data}); mi++;
            end
            @(negedge clk);
        end
        chk("fill_busy", 64'(idle), 64'd0);
        do_reset();
        chk("mr_write_reg", 64'(write_reg), 64'd0);
        chk("mr_idle",      64'(idle), 64'd1);
        chk("mr_alu_ready", 64'(alu_ready), 64'd1);
        chk("mr_mem_ready", 64'(mem_ready), 64'd1);
        chk("mr_pending",   64'(query_pending), 64'd0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (write_reg != 5'd0) bad++;
        end
        chk("mr_no_writes", 64'(bad), 64'd0);
        chk("mr_rf_clear",  rf[20], 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
